// File: rtl/common_pkg.sv
// Shared issue-stage types and register-file geometry.
package common_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = $clog2(NUM_REGS);

  typedef enum logic [0:0] {
    ISSUE_RUN       = 1'b0,
    ISSUE_JUMP_WAIT = 1'b1
  } issue_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register write-pending scoreboard with three effective-busy lookups.
// Lookups are combinational with same-cycle writeback bypass; set beats clear.
// No backpressure: set/clear are applied every edge they are asserted.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] look_a_addr,
  input  logic [REG_W-1:0] look_b_addr,
  input  logic [REG_W-1:0] look_c_addr,
  output logic             look_a_busy,
  output logic             look_b_busy,
  output logic             look_c_busy
);

  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:0] busy_full;

  // x0 has no storage; it always reads idle.
  assign busy_full = {busy, 1'b0};

  function automatic logic eff_busy(input logic [REG_W-1:0] addr);
    return busy_full[addr] & ~(clr_en & (clr_rd == addr));
  endfunction

  assign look_a_busy = eff_busy(look_a_addr);
  assign look_b_busy = eff_busy(look_b_addr);
  assign look_c_busy = eff_busy(look_c_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (set_en && (set_rd == REG_W'(r)))
          busy[r] <= 1'b1;
        else if (clr_en && (clr_rd == REG_W'(r)))
          busy[r] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/issue_controller.sv
// Issue sequencer: scoreboard hazard stall, jump fetch freeze, stall counters.
// Zero-cycle dec_valid -> issue_valid when hazard-free; fetch_hold is registered.
// Holds issue_valid until ex_ready; backpressure cycles are not counted as stalls.
module issue_controller #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic             dec_rs1_en,
  input  logic             dec_rs2_en,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_rd_en,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_stall,
  output logic             issue_valid,
  input  logic             ex_ready,
  output logic             dec_ready,
  output logic             fetch_hold,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             jump_done,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] jump_stall_cnt
);

  import common_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  issue_state_t state, state_nxt;
  logic rs1_busy, rs2_busy, rd_busy;
  logic hazard, run, fire;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (fire & dec_rd_en),
    .set_rd      (dec_rd),
    .clr_en      (wb_valid),
    .clr_rd      (wb_rd),
    .look_a_addr (dec_rs1),
    .look_b_addr (dec_rs2),
    .look_c_addr (dec_rd),
    .look_a_busy (rs1_busy),
    .look_b_busy (rs2_busy),
    .look_c_busy (rd_busy)
  );

  assign hazard = (dec_rs1_en & rs1_busy) | (dec_rs2_en & rs2_busy) | (dec_rd_en & rd_busy);
  assign run    = (state == ISSUE_RUN);

  // Gated by rst_n so nothing is offered while reset is held, even with dec_valid high.
  assign issue_valid = rst_n & run & dec_valid & ~hazard;
  assign fire        = issue_valid & ex_ready;
  assign dec_ready   = fire;
  assign fetch_hold  = (state == ISSUE_JUMP_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE_RUN:       if (fire && dec_stall) state_nxt = ISSUE_JUMP_WAIT;
      ISSUE_JUMP_WAIT: if (jump_done)         state_nxt = ISSUE_RUN;
      default:                                state_nxt = ISSUE_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ISSUE_RUN;
      hazard_stall_cnt <= '0;
      jump_stall_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (run && dec_valid && hazard && (hazard_stall_cnt != CNT_MAX))
        hazard_stall_cnt <= hazard_stall_cnt + 1'b1;
      if (!run && (jump_stall_cnt != CNT_MAX))
        jump_stall_cnt <= jump_stall_cnt + 1'b1;
    end
  end

endmodule
